// File: rtl/lake_pkg.sv
// Shared types and constants for the issue/operand path.
package lake_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef logic [REG_W-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // Operand source select: x0 reads zero, a matching writeback wins over the register file.
    function automatic logic [XLEN-1:0] fwd_operand(
        input reg_idx_t        rs,
        input logic            wb_en,
        input reg_idx_t        wb_rd,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] rf_val
    );
        if (rs == REG_ZERO) begin
            return '0;
        end
        if (wb_en && (wb_rd == rs)) begin
            return wb_val;
        end
        return rf_val;
    endfunction

endpackage

// File: rtl/scoreboard.sv
// Busy bits for in-flight destination registers; x0 never busy, set beats clear.
module scoreboard
    import lake_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst_n,
    input  logic     i_set_en,
    input  reg_idx_t i_set_idx,
    input  logic     i_clr_a_en,
    input  reg_idx_t i_clr_a_idx,
    input  logic     i_clr_b_en,
    input  reg_idx_t i_clr_b_idx,
    input  reg_idx_t i_rs1_idx,
    input  reg_idx_t i_rs2_idx,
    input  reg_idx_t i_rd_idx,
    output logic     o_rs1_busy_c,
    output logic     o_rs2_busy_c,
    output logic     o_rd_busy_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (i_clr_a_en) begin
            busy_d[i_clr_a_idx] = 1'b0;
        end
        if (i_clr_b_en) begin
            busy_d[i_clr_b_idx] = 1'b0;
        end
        if (i_set_en) begin
            busy_d[i_set_idx] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_rs1_busy_c = busy_q[i_rs1_idx];
    assign o_rs2_busy_c = busy_q[i_rs2_idx];
    assign o_rd_busy_c  = busy_q[i_rd_idx];

endmodule

// File: rtl/operand_stage.sv
// Issue/operand-read stage: hazard check against the scoreboard, writeback forwarding, output register.
module operand_stage
    import lake_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = 32
)
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [4:0]           i_rs1,
    input  logic [4:0]           i_rs2,
    input  logic [4:0]           i_rd,
    input  logic                 i_use_rs1,
    input  logic                 i_use_rs2,
    input  logic                 i_wr_rd,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic [4:0]           o_rf_rs1,
    output logic [4:0]           o_rf_rs2,
    input  logic [XLEN-1:0]      i_rf_rs1_val,
    input  logic [XLEN-1:0]      i_rf_rs2_val,
    input  logic                 i_wb_en,
    input  logic [4:0]           i_wb_rd,
    input  logic [XLEN-1:0]      i_wb_val,
    input  logic                 i_flush,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [XLEN-1:0]      o_rs1_val,
    output logic [XLEN-1:0]      o_rs2_val,
    output logic [4:0]           o_rd,
    output logic                 o_wr_rd,
    output logic [PAYLOAD_W-1:0] o_payload
);

    logic rs1_busy_c;
    logic rs2_busy_c;
    logic rd_busy_c;
    logic hazard_c;
    logic accept_c;
    logic flush_clr_c;

    logic                 valid_q;
    logic [XLEN-1:0]      rs1_val_q;
    logic [XLEN-1:0]      rs2_val_q;
    reg_idx_t             rd_q;
    logic                 wr_rd_q;
    logic [PAYLOAD_W-1:0] payload_q;

    assign o_rf_rs1 = i_rs1;
    assign o_rf_rs2 = i_rs2;

    // A writeback landing this cycle resolves the hazard on its register.
    always_comb begin
        hazard_c = 1'b0;
        if (i_use_rs1 && (i_rs1 != REG_ZERO) && rs1_busy_c && !(i_wb_en && (i_wb_rd == i_rs1))) begin
            hazard_c = 1'b1;
        end
        if (i_use_rs2 && (i_rs2 != REG_ZERO) && rs2_busy_c && !(i_wb_en && (i_wb_rd == i_rs2))) begin
            hazard_c = 1'b1;
        end
        if (i_wr_rd && (i_rd != REG_ZERO) && rd_busy_c && !(i_wb_en && (i_wb_rd == i_rd))) begin
            hazard_c = 1'b1;
        end
    end

    assign o_ready     = (!valid_q || i_ready) && !hazard_c && !i_flush;
    assign accept_c    = i_valid && o_ready;
    // Only a live entry owns its busy bit; a stale rd after drain must not clear it.
    assign flush_clr_c = i_flush && valid_q && wr_rd_q;

    scoreboard u_sb (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_set_en     (accept_c && i_wr_rd),
        .i_set_idx    (i_rd),
        .i_clr_a_en   (i_wb_en),
        .i_clr_a_idx  (i_wb_rd),
        .i_clr_b_en   (flush_clr_c),
        .i_clr_b_idx  (rd_q),
        .i_rs1_idx    (i_rs1),
        .i_rs2_idx    (i_rs2),
        .i_rd_idx     (i_rd),
        .o_rs1_busy_c (rs1_busy_c),
        .o_rs2_busy_c (rs2_busy_c),
        .o_rd_busy_c  (rd_busy_c)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q   <= 1'b0;
            rs1_val_q <= '0;
            rs2_val_q <= '0;
            rd_q      <= '0;
            wr_rd_q   <= 1'b0;
            payload_q <= '0;
        end else if (accept_c) begin
            valid_q   <= 1'b1;
            rs1_val_q <= fwd_operand(i_rs1, i_wb_en, i_wb_rd, i_wb_val, i_rf_rs1_val);
            rs2_val_q <= fwd_operand(i_rs2, i_wb_en, i_wb_rd, i_wb_val, i_rf_rs2_val);
            rd_q      <= i_rd;
            wr_rd_q   <= i_wr_rd;
            payload_q <= i_payload;
        end else if (i_flush || i_ready) begin
            valid_q   <= 1'b0;
        end
    end

    assign o_valid   = valid_q;
    assign o_rs1_val = rs1_val_q;
    assign o_rs2_val = rs2_val_q;
    assign o_rd      = rd_q;
    assign o_wr_rd   = wr_rd_q;
    assign o_payload = payload_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: per-cycle vector table plus an asynchronous-reset sequence.
module tb_operand_stage;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [4:0]  i_rs1, i_rs2, i_rd;
    logic        i_use_rs1, i_use_rs2, i_wr_rd;
    logic [31:0] i_payload;
    logic [4:0]  o_rf_rs1, o_rf_rs2;
    logic [31:0] i_rf_rs1_val, i_rf_rs2_val;
    logic        i_wb_en;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_val;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_rs1_val, o_rs2_val;
    logic [4:0]  o_rd;
    logic        o_wr_rd;
    logic [31:0] o_payload;

    operand_stage #(.PAYLOAD_W(32)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .i_rd         (i_rd),
        .i_use_rs1    (i_use_rs1),
        .i_use_rs2    (i_use_rs2),
        .i_wr_rd      (i_wr_rd),
        .i_payload    (i_payload),
        .o_rf_rs1     (o_rf_rs1),
        .o_rf_rs2     (o_rf_rs2),
        .i_rf_rs1_val (i_rf_rs1_val),
        .i_rf_rs2_val (i_rf_rs2_val),
        .i_wb_en      (i_wb_en),
        .i_wb_rd      (i_wb_rd),
        .i_wb_val     (i_wb_val),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_rs1_val    (o_rs1_val),
        .o_rs2_val    (o_rs2_val),
        .o_rd         (o_rd),
        .o_wr_rd      (o_wr_rd),
        .o_payload    (o_payload)
    );

    typedef struct {
        logic        valid;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use1;
        logic        use2;
        logic        wr;
        logic [31:0] rf1;
        logic [31:0] rf2;
        logic        wbe;
        logic [4:0]  wbrd;
        logic [31:0] wbval;
        logic        flush;
        logic        rdy;
        logic [31:0] pay;
        logic        e_ready;
        logic        e_ov;
        logic [31:0] e_v1;
        logic [31:0] e_v2;
        logic [4:0]  e_rd;
        logic        e_wr;
        logic [31:0] e_pay;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   step     = -1;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, step, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        i_valid      = v.valid;
        i_rs1        = v.rs1;
        i_rs2        = v.rs2;
        i_rd         = v.rd;
        i_use_rs1    = v.use1;
        i_use_rs2    = v.use2;
        i_wr_rd      = v.wr;
        i_rf_rs1_val = v.rf1;
        i_rf_rs2_val = v.rf2;
        i_wb_en      = v.wbe;
        i_wb_rd      = v.wbrd;
        i_wb_val     = v.wbval;
        i_flush      = v.flush;
        i_ready      = v.rdy;
        i_payload    = v.pay;
    endtask

    task automatic chk_outputs(input vec_t v);
        chk("o_valid", 32'(o_valid), 32'(v.e_ov));
        if (v.e_ov) begin
            chk("o_rs1_val", o_rs1_val, v.e_v1);
            chk("o_rs2_val", o_rs2_val, v.e_v2);
            chk("o_rd", 32'(o_rd), 32'(v.e_rd));
            chk("o_wr_rd", 32'(o_wr_rd), 32'(v.e_wr));
            chk("o_payload", o_payload, v.e_pay);
        end
    endtask

    task automatic chk_cleared();
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_rs1_val", o_rs1_val, 32'd0);
        chk("rst_o_rs2_val", o_rs2_val, 32'd0);
        chk("rst_o_rd", 32'(o_rd), 32'd0);
        chk("rst_o_wr_rd", 32'(o_wr_rd), 32'd0);
        chk("rst_o_payload", o_payload, 32'd0);
    endtask

    initial begin
        vec_t idle;
        vec_t v;
        idle = '{0,0,0,0,0,0,0,0,0,0,0,0,0,1,0, 1,0,0,0,0,0,0};

        // valid rs1 rs2 rd u1 u2 wr rf1 rf2 wbe wbrd wbval fl rdy pay | ready ov v1 v2 rd wr pay
        vecs.push_back('{1, 2, 3, 1,1,1,1,'h11,'h22,0,0,0,0,1,'hA1, 1,1,'h11,'h22,1,1,'hA1});
        vecs.push_back('{1, 4, 6, 2,1,1,1,'h11,'h22,0,0,0,0,1,'hA2, 1,1,'h11,'h22,2,1,'hA2});
        vecs.push_back('{1, 8, 9, 3,1,1,1,'h11,'h22,0,0,0,0,1,'hA3, 1,1,'h11,'h22,3,1,'hA3});
        vecs.push_back('{1,10, 0, 5,1,0,1,'h55,'h99,0,0,0,0,1,'hA4, 1,1,'h55,0,5,1,'hA4});
        // RAW on r5 stalls until the writeback arrives, then forwards it
        vecs.push_back('{1, 5, 0, 6,1,0,1,'h1234,0,0,0,0,0,1,'hB1, 0,0,0,0,0,0,0});
        vecs.push_back('{1, 5, 0, 6,1,0,1,'h1234,0,0,0,0,0,1,'hB1, 0,0,0,0,0,0,0});
        vecs.push_back('{1, 5, 0, 6,1,0,1,'h1234,0,1,5,'hDEADBEEF,0,1,'hB1, 1,1,'hDEADBEEF,0,6,1,'hB1});
        // r5 now free; r1 busy but satisfied by same-cycle writeback
        vecs.push_back('{1, 1, 5, 0,1,1,0,'hAAAA,'hBBBB,1,1,'h01010101,0,1,'hB2, 1,1,'h01010101,'hBBBB,0,0,'hB2});
        // x0 source reads zero even with a writeback to x0
        vecs.push_back('{1, 0, 0, 0,1,0,1,'h77,0,1,0,'hFFFF,0,1,'hB3, 1,1,0,0,0,1,'hB3});
        // WAW on r3
        vecs.push_back('{1, 0, 0, 3,0,0,1,0,0,0,0,0,0,1,'hC1, 0,0,0,0,0,0,0});
        vecs.push_back('{1, 0, 0, 3,0,0,1,0,0,1,3,'h3333,0,1,'hC1, 1,1,0,0,3,1,'hC1});
        // set of r3 beat the same-cycle clear: r3 still busy
        vecs.push_back('{1, 3, 0, 4,1,0,1,'h44,0,0,0,0,0,1,'hC2, 0,0,0,0,0,0,0});
        vecs.push_back('{1, 0, 0, 7,0,0,1,0,0,0,0,0,0,1,'hC7, 1,1,0,0,7,1,'hC7});
        // downstream backpressure for 4 cycles
        for (int k = 0; k < 4; k++) begin
            vecs.push_back('{1, 0, 0, 8,0,0,1,'h88,'h88,0,0,0,0,0,'hC8, 0,1,0,0,7,1,'hC7});
        end
        // flush the held r7 entry, then an r7 consumer issues freely
        vecs.push_back('{1, 0, 0, 8,0,0,1,'h88,'h88,0,0,0,1,0,'hC8, 0,0,0,0,0,0,0});
        vecs.push_back('{1, 7, 0, 0,1,0,0,'h700,0,0,0,0,0,1,'hD1, 1,1,'h700,0,0,0,'hD1});
        // set up a held entry plus a blocked consumer for the reset sequence
        vecs.push_back('{1, 0, 0, 9,0,0,1,0,0,0,0,0,0,1,'hE1, 1,1,0,0,9,1,'hE1});
        vecs.push_back('{1, 9, 0,10,1,0,1,'h900,0,0,0,0,0,0,'hE2, 0,1,0,0,9,1,'hE1});

        drive(idle);
        i_rst_n = 1'b0;
        #12;
        chk_cleared();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        chk("o_ready_after_reset", 32'(o_ready), 32'd1);

        foreach (vecs[i]) begin
            step = i;
            @(negedge i_clk);
            drive(vecs[i]);
            #1;
            chk("o_ready", 32'(o_ready), 32'(vecs[i].e_ready));
            chk("o_rf_rs1", 32'(o_rf_rs1), 32'(vecs[i].rs1));
            @(posedge i_clk);
            #1;
            chk_outputs(vecs[i]);
        end

        // asynchronous reset mid-stall, away from any clock edge
        step = 100;
        v = vecs[vecs.size()-1];
        @(negedge i_clk);
        drive(v);
        #1;
        chk("stall_before_reset", 32'(o_ready), 32'd0);
        #1;
        i_rst_n = 1'b0;
        #1;
        chk_cleared();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        v.rdy = 1'b1;
        drive(v);
        #1;
        chk("o_ready_unblocked", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;
        v.e_ov  = 1'b1;
        v.e_v1  = 32'h900;
        v.e_v2  = 32'h0;
        v.e_rd  = 5'd10;
        v.e_wr  = 1'b1;
        v.e_pay = 32'hE2;
        chk_outputs(v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/operand_stage.md
# operand_stage

Issue/operand-read stage directly upstream of the 32x32 register file. Accepts decoded instructions over valid/ready, drives the register file read addresses, and forwards same-cycle writeback data. Tracks in-flight destination registers in a 32-entry scoreboard, stalls on RAW/WAW hazards, and presents registered operands to the execute stage over valid/ready.

## Interface
- `XLEN`, 32, operand width
- `PAYLOAD_W`, 32, opaque decoded-instruction payload (opcode/imm/etc.), passed through untouched
- `i_clk` in 1: clock; all state updates on its rising edge
- `i_rst_n` in 1: reset, asynchronous, active-low
- `i_valid` in 1: upstream instruction valid
- `o_ready` out 1: stage can accept this cycle
- `i_rs1`, `i_rs2`, `i_rd` in 5: register indices
- `i_use_rs1`, `i_use_rs2`, `i_wr_rd` in 1: source-used and destination-written flags
- `i_payload` in PAYLOAD_W: pass-through
- `o_rf_rs1`, `o_rf_rs2` out 5: register-file read addresses, combinational copies of `i_rs1`/`i_rs2`
- `i_rf_rs1_val`, `i_rf_rs2_val` in XLEN: register-file read data, combinational
- `i_wb_en` in 1, `i_wb_rd` in 5, `i_wb_val` in XLEN: writeback port, shared with the register-file write port
- `i_flush` in 1: discard the held output entry
- `o_valid` out 1, `i_ready` in 1: downstream handshake
- `o_rs1_val`, `o_rs2_val` out XLEN; `o_rd` out 5; `o_wr_rd` out 1; `o_payload` out PAYLOAD_W: registered outputs

## Operation
- Scoreboard: 32 busy bits; bit 0 is hardwired 0.
- Issue hazard:
  - Stall if `i_use_rs1` && rs1!=0 && busy[rs1] && !(wb_en && wb_rd==rs1). Same rule for rs2.
  - Stall if `i_wr_rd` && rd!=0 && busy[rd] && !(wb_en && wb_rd==rd) (WAW).
- `o_ready` = (!o_valid || i_ready) && !hazard && !i_flush.
- Accept when `i_valid && o_ready`. On accept, the output register loads:
  - Operands: `i_wb_val` if wb_en && wb_rd==rsN && rsN!=0; otherwise the register-file value. rsN==0 yields 0.
  - `o_rd`, `o_wr_rd`, `o_payload`.
- Busy update per cycle:
  - Clear busy[wb_rd] on wb_en.
  - Set busy[rd] on accept with wr_rd && rd!=0.
  - Set and clear of the same index in one cycle: set wins.
- Output register:
  - When `o_valid && i_ready && !accept`, `o_valid` goes to 0.
  - When `i_ready` is low, contents hold stable.
- Flush:
  - `o_valid` goes to 0 next cycle and no accept occurs.
  - If the flushed entry had `o_wr_rd` && `o_rd`!=0, clear its busy bit.
  - Writebacks that same cycle still clear their bits.

## Timing
- Reset: `o_valid`=0, all busy=0, `o_rs1_val`/`o_rs2_val`/`o_rd`/`o_wr_rd`/`o_payload`=0. `o_ready` is 1 once reset deasserts.
- Reset asserted mid-operation drops any held entry and all scoreboard state immediately.
- Latency: accept in cycle N gives `o_valid` in N+1.
- Throughput: one instruction per cycle when there are no hazards and `i_ready` is high.
- `o_valid`, once high, stays high with stable data until `i_ready` or `i_flush`.
- A writeback in cycle N satisfies a consumer accepted in cycle N via forwarding.

## Structure
- Shared package `lake_pkg`: `XLEN`, `reg_idx_t` (logic [4:0]), `REG_ZERO`.
- Sub-module `scoreboard`: 32 busy bits with set/clear ports, set-wins priority, two read ports plus one rd-check port.
- Forwarding muxes and the output register stay in `operand_stage`.

## Test plan
- Back-to-back independent instructions (rd=1,2,3; regfile returns 0x11/0x22): `o_valid` on consecutive cycles, one cycle after each accept.
- Issue rd=5, then a consumer of rs1=5 with no wb: `o_ready`=0. Pulse wb_en/wb_rd=5/wb_val=0xDEADBEEF: consumer accepted that cycle with `o_rs1_val`=0xDEADBEEF and busy[5] cleared.
- rs1=0 with busy clear and wb to rd=0 of 0xFFFF: `o_rs1_val`=0 and no stall.
- Hold `i_ready`=0 for 4 cycles with `o_valid`=1: outputs stable, `o_ready`=0, no accept.
- Flush a held entry with rd=7: `o_valid`=0 next cycle, busy[7]=0, and a following rs1=7 consumer issues without stall.
- Assert `i_rst_n`=0 asynchronously mid-stall: outputs and busy bits are 0 immediately. After release, the previously blocked instruction issues.
